// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the 5-stage datapath and pipe_hazard_ctrl.
// The master side is the datapath and the slave side is the sequencer.
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs2;
  logic [4:0] ex_rd;
  logic       ex_d_rd;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       dbg_halt;
  logic       dbg_step;

  logic       pc_en;
  logic       if_id_en;
  logic       id_ex_en;
  logic       ex_m_en;
  logic       m_wb_en;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       m_wb_flush;
  logic       stall;
  logic       halted;
  logic       mem_fault;

  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_d_rd, ex_branch_taken,
           mem_req, mem_ready, dbg_halt, dbg_step,
    input  pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en,
           if_id_flush, id_ex_flush, m_wb_flush, stall, halted, mem_fault
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_d_rd, ex_branch_taken,
           mem_req, mem_ready, dbg_halt, dbg_step,
    output pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en,
           if_id_flush, id_ex_flush, m_wb_flush, stall, halted, mem_fault
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, branch flushes, data-memory freeze with timeout, debug halt/step.
// Define PIPE_PERF_CNT_EN to add the perf_stall_cnt / perf_flush_cnt saturating counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_hazard_ctrl_if.slave   bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    perf_stall_cnt,
  output logic [CNT_W-1:0]    perf_flush_cnt
`endif
);

  localparam int unsigned WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2,
    FAULT    = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;

  logic mem_stall;
  logic branch;
  logic load_use;
  logic eval;
  logic freeze;

  logic pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en;
  logic if_id_flush, id_ex_flush, m_wb_flush;
  logic stall;

  assign mem_stall = bus.mem_req & ~bus.mem_ready;
  assign branch    = bus.ex_branch_taken;
  assign load_use  = bus.ex_d_rd & (bus.ex_rd != '0) &
                     ((bus.ex_rd == bus.id_rs1) |
                      (bus.id_uses_rs2 & (bus.ex_rd == bus.id_rs2)));

  // eval: this cycle resolves branch/load-use/normal; freeze: memory bubble into WB
  always_comb begin
    eval   = 1'b0;
    freeze = 1'b0;
    case (state_q)
      RUN: begin
        eval   = ~mem_stall;
        freeze = mem_stall;
      end
      MEM_WAIT: begin
        eval   = bus.mem_ready;
        freeze = ~bus.mem_ready;
      end
      HALT: begin
        eval   = bus.dbg_step & ~mem_stall;
        freeze = bus.dbg_step & mem_stall;
      end
      default: begin
        eval   = 1'b0;
        freeze = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end else if (bus.dbg_halt) begin
          state_d = HALT;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ready) begin
          state_d = bus.dbg_halt ? HALT : RUN;
        end else if (wait_cnt_q == WCW'(MEM_TIMEOUT - 1)) begin
          state_d = FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      HALT: begin
        if (bus.dbg_step) begin
          if (mem_stall) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = '0;
          end
        end else if (!bus.dbg_halt) begin
          state_d = RUN;
        end
      end
      default: state_d = FAULT;
    endcase
  end

  // Mealy outputs; rst_n gating forces them low for the whole reset interval
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_m_en     = 1'b0;
    m_wb_en     = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    m_wb_flush  = 1'b0;
    if (rst_n) begin
      if (freeze) begin
        m_wb_en    = 1'b1;
        m_wb_flush = 1'b1;
      end else if (eval) begin
        if (branch) begin
          pc_en       = 1'b1;
          if_id_en    = 1'b1;
          id_ex_en    = 1'b1;
          ex_m_en     = 1'b1;
          m_wb_en     = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          id_ex_en    = 1'b1;
          ex_m_en     = 1'b1;
          m_wb_en     = 1'b1;
          id_ex_flush = 1'b1;
        end else begin
          pc_en    = 1'b1;
          if_id_en = 1'b1;
          id_ex_en = 1'b1;
          ex_m_en  = 1'b1;
          m_wb_en  = 1'b1;
        end
      end
    end
  end

  assign stall = rst_n & ~pc_en;

  assign bus.pc_en       = pc_en;
  assign bus.if_id_en    = if_id_en;
  assign bus.id_ex_en    = id_ex_en;
  assign bus.ex_m_en     = ex_m_en;
  assign bus.m_wb_en     = m_wb_en;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.m_wb_flush  = m_wb_flush;
  assign bus.stall       = stall;
  assign bus.halted      = rst_n & (state_q == HALT);
  assign bus.mem_fault   = rst_n & (state_q == FAULT);

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (state_q == RUN || state_q == MEM_WAIT) && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (eval && branch && flush_cnt_q != '1) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
// Output vector order: pc,ifid,idex,exm,mwb en | ifid,idex,mwb flush | stall,halted,fault.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  pipe_hazard_ctrl_if bus ();

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(4),
    .CNT_W      (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef PIPE_PERF_CNT_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [10:0] V_ZERO  = 11'b00000_000_000;
  localparam logic [10:0] V_RUN   = 11'b11111_000_000;
  localparam logic [10:0] V_BR    = 11'b11111_110_000;
  localparam logic [10:0] V_LU    = 11'b00111_010_100;
  localparam logic [10:0] V_FRZ   = 11'b00001_001_100;
  localparam logic [10:0] V_HALT  = 11'b00000_000_110;
  localparam logic [10:0] V_STEP  = 11'b11111_000_010;
  localparam logic [10:0] V_FAULT = 11'b00000_000_101;

  logic [10:0] outs;
  assign outs = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_m_en, bus.m_wb_en,
                 bus.if_id_flush, bus.id_ex_flush, bus.m_wb_flush,
                 bus.stall, bus.halted, bus.mem_fault};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    bus.id_rs1          = '0;
    bus.id_rs2          = '0;
    bus.id_uses_rs2     = 1'b0;
    bus.ex_rd           = '0;
    bus.ex_d_rd         = 1'b0;
    bus.ex_branch_taken = 1'b0;
    bus.mem_req         = 1'b0;
    bus.mem_ready       = 1'b0;
    bus.dbg_halt        = 1'b0;
    bus.dbg_step        = 1'b0;
  endtask

  // Inputs are set at the falling edge; outputs checked 1ns later, then advance one cycle.
  task automatic cyc(input string tag, input logic [10:0] exp);
    #1;
    chk(tag, {21'd0, outs}, {21'd0, exp});
    @(negedge clk);
  endtask

  initial begin
    clr_in();
    rst_n = 1'b0;
    #2;
    chk("reset", {21'd0, outs}, {21'd0, V_ZERO});
    @(negedge clk);
    rst_n = 1'b1;

    cyc("idle", V_RUN);

    bus.ex_d_rd = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5;
    cyc("lu_rs1", V_LU);
    bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0;
    cyc("lu_x0", V_RUN);
    bus.ex_rd = 5'd7; bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd7; bus.id_uses_rs2 = 1'b0;
    cyc("lu_rs2_unused", V_RUN);
    bus.id_uses_rs2 = 1'b1;
    cyc("lu_rs2", V_LU);
    bus.ex_d_rd = 1'b0;
    cyc("lu_not_load", V_RUN);

    bus.ex_d_rd = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.ex_branch_taken = 1'b1;
    cyc("br_over_lu", V_BR);
    clr_in();

    bus.mem_req = 1'b1;
    cyc("mw_detect", V_FRZ);
    cyc("mw_wait1", V_FRZ);
    cyc("mw_wait2", V_FRZ);
    bus.mem_ready = 1'b1;
    cyc("mw_resume", V_RUN);
    clr_in();
    cyc("mw_back_run", V_RUN);

    bus.mem_req = 1'b1; bus.ex_branch_taken = 1'b1;
    cyc("mwbr_detect", V_FRZ);
    bus.mem_ready = 1'b1;
    cyc("mwbr_resolve", V_BR);
    clr_in();
`ifdef PIPE_PERF_CNT_EN
    chk("perf_stall", perf_stall_cnt, 32'd6);
    chk("perf_flush", perf_flush_cnt, 32'd2);
`endif

    bus.dbg_halt = 1'b1;
    cyc("halt_req", V_RUN);
    cyc("halted1", V_HALT);
    cyc("halted2", V_HALT);
    bus.dbg_step = 1'b1;
    cyc("step", V_STEP);
    bus.dbg_step = 1'b0;
    cyc("after_step", V_HALT);
    bus.dbg_halt = 1'b0;
    cyc("release_cyc", V_HALT);
    cyc("resumed", V_RUN);

    bus.mem_req = 1'b1;
    cyc("mwh_detect", V_FRZ);
    bus.mem_ready = 1'b1; bus.dbg_halt = 1'b1;
    cyc("mwh_resume", V_RUN);
    clr_in(); bus.dbg_halt = 1'b1;
    cyc("mwh_halted", V_HALT);
    bus.dbg_halt = 1'b0;
    cyc("mwh_release", V_HALT);
    cyc("mwh_run", V_RUN);

    bus.mem_req = 1'b1;
    cyc("to_c0", V_FRZ);
    cyc("to_c1", V_FRZ);
    cyc("to_c2", V_FRZ);
    cyc("to_c3", V_FRZ);
    cyc("to_c4", V_FRZ);
    cyc("to_fault", V_FAULT);
    bus.mem_ready = 1'b1;
    cyc("fault_ready", V_FAULT);
    clr_in();
    cyc("fault_sticky", V_FAULT);

    rst_n = 1'b0;
    #1;
    chk("reset_fault", {21'd0, outs}, {21'd0, V_ZERO});
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_reset", V_RUN);
    bus.mem_req = 1'b1;
    cyc("rw_detect", V_FRZ);
    #3;
    rst_n = 1'b0;
    #1;
    chk("reset_midwait", {21'd0, outs}, {21'd0, V_ZERO});
    @(negedge clk);
    clr_in();
    rst_n = 1'b1;
`ifdef PIPE_PERF_CNT_EN
    chk("perf_stall_rst", perf_stall_cnt, 32'd0);
    chk("perf_flush_rst", perf_flush_cnt, 32'd0);
`endif
    cyc("rw_run", V_RUN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline sequencer for the 5-stage RV32 core. It drives per-stage enable and flush signals for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC register, and resolves four conditions:
- load-use hazards (bubble insertion);
- taken branches and jumps (wrong-path flush);
- multi-cycle data-memory accesses (pipeline freeze, with a timeout fault);
- debug halt and single-step.

It sits beside the datapath and takes only decoded register indices and status bits from it.

## Interface
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before fault; legal range ≥1.
- CNT_W, 32: width of the performance counters.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID (IF/ID outputs)
- id_uses_rs2  in  1  instruction in ID reads rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_d_rd  in  1  instruction in EX is a load
- ex_branch_taken  in  1  EX has resolved a taken branch or jump
- mem_req  in  1  MEM stage is accessing data memory (load or store)
- mem_ready  in  1  data memory completes the access this cycle
- dbg_halt  in  1  level request to halt
- dbg_step  in  1  single-cycle pulse: advance one cycle while halted
- pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en  out  1 each  register load enables
- if_id_flush, id_ex_flush, m_wb_flush  out  1 each  synchronous clear of the target register at the next edge
- stall  out  1  pc_en is 0
- halted  out  1  FSM is in HALT
- mem_fault  out  1  memory timeout occurred (sticky)

## Operation
- FSM states: RUN, MEM_WAIT, HALT, FAULT. All outputs are Mealy, decoded from the current state and the inputs in the same cycle.
- Action evaluation in RUN, in the step cycle of HALT, and in MEM_WAIT when mem_ready=1. Highest priority first:
  1. **Mem stall** (mem_req & !mem_ready):
     - pc_en, if_id_en, id_ex_en, ex_m_en = 0;
     - m_wb_en = 1 and m_wb_flush = 1 (bubble into WB);
     - next state MEM_WAIT, wait_cnt cleared to 0.
  2. **Branch** (ex_branch_taken):
     - all enables = 1;
     - if_id_flush = id_ex_flush = 1.
  3. **Load-use**: ex_d_rd & ex_rd≠0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)):
     - pc_en = if_id_en = 0;
     - id_ex_flush = 1;
     - other enables = 1.
  4. **Otherwise**: all enables = 1, no flush.
- **MEM_WAIT, mem_ready=0**:
  - freeze outputs as in mem stall;
  - if wait_cnt == MEM_TIMEOUT-1, next state FAULT; else wait_cnt increments.
- **MEM_WAIT, mem_ready=1**:
  - evaluate the action list with mem stall treated as false;
  - next state HALT if dbg_halt=1, else RUN.
  - A branch or load-use held in EX during the wait is therefore resolved in this cycle.
- **RUN with dbg_halt=1 and no mem stall**: the current cycle executes normally; next state HALT.
- **HALT**:
  - dbg_step=0: all enables 0, no flush.
  - dbg_step=1: normal evaluation for one cycle; next state MEM_WAIT if mem stall, else HALT.
  - dbg_halt=0 and dbg_step=0: next state RUN.
- **FAULT**: all enables 0, no flush, mem_fault=1. Only rst_n exits this state.

## Timing
- Reset (rst_n=0), asynchronous:
  - state = RUN, wait_cnt = 0;
  - all enables and flushes forced to 0;
  - stall = 0, halted = 0, mem_fault = 0;
  - counters = 0.
- Hazard responses take effect in the same cycle the condition is present (zero latency). The load-use penalty is exactly 1 bubble; the branch penalty is 2 flushed instructions.
- Stall cycles before FAULT with mem_ready held at 0: 1 detection cycle + MEM_TIMEOUT MEM_WAIT cycles.
- mem_ready rising in any MEM_WAIT cycle resumes the pipeline in that same cycle.

## Configuration
- PIPE_PERF_CNT_EN defined: adds two output ports, each a CNT_W-bit saturating counter:
  - perf_stall_cnt: cycles with stall=1, excluding HALT and FAULT;
  - perf_flush_cnt: branch-flush events.
- PIPE_PERF_CNT_EN undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- **Load-use**: ex_d_rd=1, ex_rd=5, id_rs1=5 for 1 cycle → pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; with ex_rd=0 → no stall.
- **Branch vs load-use**: ex_branch_taken=1 together with a load-use match → if_id_flush=id_ex_flush=1, pc_en=1; perf_flush_cnt +1.
- **Memory wait**: mem_req=1, mem_ready low for 3 cycles then high → 3 frozen cycles with m_wb_flush=1, full advance on the 4th cycle, state RUN.
- **Timeout**: MEM_TIMEOUT=4, mem_req=1, mem_ready=0 from cycle 0 → MEM_WAIT in cycles 1–4, mem_fault=1 from cycle 5, held until rst_n; later mem_ready=1 is ignored.
- **Debug**: dbg_halt=1 → halted=1 next cycle with all enables 0. Each dbg_step pulse → exactly one cycle with enables=1. dbg_halt=0 → RUN.
- **Reset mid-wait**: rst_n low during MEM_WAIT → all outputs 0 immediately; after release, state is RUN and counters read 0.
